// File: rtl/dreg_pkg.sv
// Shared types and constants for the dreg_readout register bank and scan engine.
// Holds the FSM encoding and the address-width helper used by every file.
package dreg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(v)), but never below 1 so a two-entry bank still has an address bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dreg_bank.sv
// M x N register array with one write port and two combinational read ports.
// Out-of-range addresses read as zero and are never written.
module dreg_bank
  import dreg_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 2,
  localparam int AW = clog2_min1(M)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [N-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_a_addr,
  output logic [N-1:0]  o_rd_a_data,
  input  logic [AW-1:0] i_rd_b_addr,
  output logic [N-1:0]  o_rd_b_data
);

  logic [N-1:0] r_mem [M];
  logic         w_wr_ok;
  logic         w_rd_a_ok;
  logic         w_rd_b_ok;

  assign w_wr_ok   = int'(i_wr_addr)   < M;
  assign w_rd_a_ok = int'(i_rd_a_addr) < M;
  assign w_rd_b_ok = int'(i_rd_b_addr) < M;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < M; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en && w_wr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old value.
  always_comb begin
    o_rd_a_data = '0;
    o_rd_b_data = '0;
    if (w_rd_a_ok) begin
      o_rd_a_data = r_mem[i_rd_a_addr];
    end
    if (w_rd_b_ok) begin
      o_rd_b_data = r_mem[i_rd_b_addr];
    end
  end

endmodule

// File: rtl/dreg_readout.sv
// Register bank with a registered random-read port and a scan engine that
// streams every entry in address order over a valid/ready handshake.
module dreg_readout
  import dreg_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 2,
  localparam int AW = clog2_min1(M)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [N-1:0]  rd_data,
  input  logic          start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output state_t        dbg_state
);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // out_valid stays high with out_data/out_addr/out_last frozen until then.

  localparam logic [AW-1:0] LAST_ADDR = AW'(M - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic          w_load;
  logic          w_advance;
  logic          w_finish;
  logic [AW-1:0] w_scan_addr;
  logic [N-1:0]  w_scan_data;
  logic [N-1:0]  w_rd_data;

  logic [N-1:0]  r_rd_data;
  logic          r_out_valid;
  logic [N-1:0]  r_out_data;
  logic [AW-1:0] r_out_addr;
  logic          r_out_last;

  // The scan port looks ahead at the entry the next beat will present.
  assign w_scan_addr = (r_state == IDLE) ? '0 : (r_out_addr + AW'(1));

  dreg_bank #(
    .N(N),
    .M(M)
  ) u_bank (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_wr_en    (wr_en),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rd_a_addr(rd_addr),
    .o_rd_a_data(w_rd_data),
    .i_rd_b_addr(w_scan_addr),
    .o_rd_b_data(w_scan_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = SCAN;
          w_load       = 1'b1;
        end
      end
      SCAN: begin
        if (r_out_valid && out_ready) begin
          if (r_out_addr == LAST_ADDR) begin
            w_next_state = DONE;
            w_finish     = 1'b1;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_rd_data <= w_rd_data;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_addr  <= '0;
        r_out_data  <= w_scan_data;
        r_out_last  <= 1'b0;
      end else if (w_advance) begin
        r_out_addr <= w_scan_addr;
        r_out_data <= w_scan_data;
        r_out_last <= (w_scan_addr == LAST_ADDR);
      end else if (w_finish) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign rd_data   = r_rd_data;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: doc/dreg_readout.md
Name: dreg_readout

Overview:
- Register bank of M entries, each N bits, with a random-access write port.
- Two read paths:
  - a registered random-access read port;
  - a scan engine that streams every entry, in address order, over a valid/ready handshake.
- Sits on the consumer side of multi-entry register arrays. It gives downstream logic (readout, monitoring) a controlled way to drain the array contents.

Parameters:
- N, 2, width of each entry in bits (N >= 1).
- M, 2, number of entries (M >= 2).
- AW, derived localparam, address width = max(1, ceil(log2(M))); not overridable.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  AW  write address; values >= M are ignored (no write).
- wr_data  input  N  write data.
- rd_addr  input  AW  random-read address.
- rd_data  output  N  registered random-read data.
- start  input  1  request a full scan; sampled only in IDLE.
- out_valid  output  1  scan data valid.
- out_ready  input  1  downstream accepts scan data.
- out_data  output  N  scanned entry contents.
- out_addr  output  AW  index of the entry on out_data.
- out_last  output  1  high with out_valid when out_addr == M-1.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (reset high at a rising edge):
  - all M entries cleared to 0;
  - rd_data=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0;
  - FSM goes to IDLE.
  - Reset overrides every other input in that cycle. Reset mid-scan aborts the scan; no done pulse is issued.
- Write:
  - wr_en=1 with wr_addr<M updates entry[wr_addr] at the edge;
  - visible to any read performed on the following cycle.
- Random read:
  - rd_data <= entry[rd_addr] every cycle, latency 1;
  - rd_addr >= M gives rd_data <= 0.
  - Same-cycle write to the same address returns the old value (read-before-write).
- FSM states: IDLE, SCAN, DONE.
  - IDLE:
    - start=1 -> SCAN, with out_valid<=1, out_addr<=0, out_data<=entry[0], out_last<=0.
    - start=0 -> stay in IDLE.
  - SCAN:
    - out_valid=1 and out_ready=0 -> hold out_data, out_addr and out_last stable. Writes to the entry currently presented do not alter out_data.
    - Handshake (out_valid & out_ready) with out_addr<M-1:
      - out_addr<=out_addr+1;
      - out_data<=entry[out_addr+1], using the pre-edge value (read-before-write);
      - out_last<=(out_addr+1==M-1).
      - This gives back-to-back beats, one per cycle, with no bubbles.
    - Handshake with out_addr==M-1 -> DONE, with out_valid<=0 and out_last<=0.
  - DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
- Start handling: start in SCAN or DONE is ignored, with no queuing. A new scan needs start while in IDLE.
- busy=1 in SCAN and DONE, combinational from state.
- The scan takes a snapshot per beat, not per scan. Writes to entries not yet presented are reflected in later beats.
- out_valid, once asserted, never drops before its handshake except on reset.

Decomposition:
- Shared package dreg_pkg:
  - FSM state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - the clog2-with-minimum-1 constant function used to derive AW.
- One sub-module, dreg_bank:
  - parameters N and M;
  - the entry array, with synchronous-reset clear and the write port;
  - two combinational read ports returning 0 for out-of-range addresses.
- dreg_readout instantiates dreg_bank and holds the rd_data register, the FSM and the scan output registers.

Test Plan (N=8, M=4 unless stated):
- Reset, then write 0x11, 0x22, 0x33, 0x44 to addresses 0..3; start with out_ready held 1 -> beats 0x11/0, 0x22/1, 0x33/2, 0x44/3 on consecutive cycles, out_last only on addr 3, done pulses one cycle after beat 3, busy falls with done.
- Same contents; out_ready toggles 1,0,0,1,0,1,1 -> out_data/out_addr held stable while ready=0, exactly four accepted beats in order, done after the 4th.
- During SCAN presenting addr 1, write 0xAA to addr 1 and 0xBB to addr 2 -> current beat stays 0x22, next beat is 0xBB; start pulsed in SCAN is ignored (done pulses once).
- Random read: write 0x5C to addr 2, rd_addr=2 on the next cycle -> rd_data=0x5C one cycle later; same-cycle write/read of addr 3 returns the old value; M=3 with rd_addr=3 -> rd_data=0, and wr_addr=3 writes nothing.
- Assert reset while presenting addr 2 -> next cycle out_valid=0, busy=0, no done pulse; a subsequent scan returns all zeros.
- start and reset asserted together in IDLE -> stays IDLE, out_valid=0.
